minimig_reset_sequencer: RTL and testbench
==========================================

Name: minimig_reset_sequencer

Overview:
- Arbitrates all reset sources and sequences staged resets into separate peripheral and CPU reset lines, plus the boot-mode flag.
- Reset sources: power-on, master/user reset, keyboard reset combo, OSD reset, 68k RESET instruction, bootloader bootdone.
- Sits between the host/OSD/keyboard/CPU request lines and the chipset/CPU reset inputs.
- Replaces the single-counter reset generator with explicit state-machine sequencing.

Parameters:
- HOLD_TICKS, 4: number of cnt pulses that full reset is held, after the last full request.
- CPU_DELAY, 8: number of clk7_en cycles the CPU stays in reset after the peripherals are released.
- INSTR_CYCLES, 124: number of clk7_en cycles the peripherals are reset by the 68k RESET instruction.

Ports:
- clk  in  1  bus clock
- reset_n  in  1  synchronous active-low reset
- clk7_en  in  1  7 MHz clock enable
- cnt  in  1  tick pulses for hold timing
- mrst  in  1  master/user reset request (level)
- kbd_rst  in  1  keyboard reset request (level)
- osd_rst  in  1  OSD reset request (level)
- cpu_rsti  in  1  68k RESET instruction pulse
- bootdone  in  1  bootloader completion pulse
- periph_reset  out  1  chipset/peripheral reset, active high
- cpu_reset  out  1  CPU reset, active high
- boot  out  1  bootrom mapping enable
- busy  out  1  any reset sequence in progress
- cause  out  3  last reset cause: 0 POR, 1 mrst, 2 kbd, 3 osd, 4 rsti, 5 bootdone

Behaviour:
- reset_n low at a clk edge (independent of clk7_en) forces:
  - state=FULL, tick and cycle counters=0
  - boot=1, cause=0
- All other state updates occur only on clk edges with clk7_en=1.
- Outputs are decoded from registered state; a request sampled at edge N is visible after edge N.
- Full request = mrst|kbd_rst|osd_rst.
- Requests are sampled only on clk7_en edges; a cpu_rsti or bootdone pulse not coincident with clk7_en is ignored.
- Request priority: mrst > kbd_rst > osd_rst > bootdone > cpu_rsti.
- FULL state: periph_reset=1, cpu_reset=1, busy=1.
  - Any full request present: tick counter=0 and cause is updated (retrigger).
  - Otherwise, cnt=1 increments the tick counter.
  - When the counter reaches HOLD_TICKS: cycle counter=0, go to CPUWAIT.
- CPUWAIT state: periph_reset=0, cpu_reset=1, busy=1.
  - Cycle counter increments each clk7_en.
  - At CPU_DELAY-1: go to RUN.
  - Full request: go to FULL, counters=0.
- RUN state: periph_reset=0, cpu_reset=0, busy=0.
  - Full request: go to FULL, cause set.
  - Else bootdone with boot=1: boot<=0, cause=5, go to FULL.
  - bootdone with boot=0: ignored.
  - Else cpu_rsti: cause=4, cycle counter=0, go to INSTR.
- INSTR state: periph_reset=1, cpu_reset=0, busy=1.
  - Cycle counter increments.
  - At INSTR_CYCLES-1: go to RUN.
  - Full request aborts to FULL.
  - Further cpu_rsti pulses are ignored (no restart).
- boot:
  - Set only by reset_n.
  - Cleared only by an accepted bootdone.
  - mrst/kbd/osd never re-assert boot.
- cnt and clk7_en coincident in FULL both count; a cnt without clk7_en is not counted.
- Counters saturate and never wrap; tick counter is sized for HOLD_TICKS, cycle counter for max(CPU_DELAY, INSTR_CYCLES).
- Simultaneous full request and bootdone in RUN: full request wins; boot stays 1.

Test Plan:
- Power-on: reset_n low 3 cycles, then high, cnt pulse every 16 clk7_en -> periph_reset=1 until the 4th cnt; cpu_reset stays 1 for 8 more clk7_en; boot=1; cause=0.
- mrst held 100 clk7_en in RUN -> FULL for the whole hold; after release, 4 cnt ticks then 8 cycles of CPUWAIT; cause=1; boot unchanged.
- cpu_rsti pulse in RUN -> periph_reset=1 for exactly 124 clk7_en, cpu_reset=0 throughout; cause=4; second pulse at cycle 50 has no effect.
- bootdone with boot=1 -> boot=0, full sequence, cause=5; second bootdone later -> no reset, boot stays 0.
- osd_rst asserted at INSTR cycle 60 -> immediate FULL (cpu_reset=1 after edge), cause=3.
- mrst and bootdone on the same clk7_en in RUN -> cause=1, boot=1; reset_n low during CPUWAIT -> state FULL, boot=1, cause=0.

Source files
------------

// File: rtl/minimig_reset_sequencer.sv
// Reset sequencer: merges power-on, user, keyboard, OSD, 68k RESET-instruction
// and bootloader-done requests into staged peripheral / CPU reset lines,
// tracks the boot-ROM mapping flag and records the last reset cause.
module minimig_reset_sequencer #(
    parameter int HOLD_TICKS   = 4,
    parameter int CPU_DELAY    = 8,
    parameter int INSTR_CYCLES = 124
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk7_en,
    input  logic       cnt,
    input  logic       mrst,
    input  logic       kbd_rst,
    input  logic       osd_rst,
    input  logic       cpu_rsti,
    input  logic       bootdone,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic       boot,
    output logic       busy,
    output logic [2:0] cause
);

    localparam int CYC_MAX = (CPU_DELAY > INSTR_CYCLES) ? CPU_DELAY : INSTR_CYCLES;
    localparam int TICK_W  = $clog2(HOLD_TICKS + 1);
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(HOLD_TICKS);
    localparam logic [CYC_W-1:0]  CYC_SAT    = CYC_W'(CYC_MAX);
    localparam logic [CYC_W-1:0]  CPU_LAST   = CYC_W'(CPU_DELAY - 1);
    localparam logic [CYC_W-1:0]  INSTR_LAST = CYC_W'(INSTR_CYCLES - 1);

    localparam logic [2:0] CAUSE_POR   = 3'd0;
    localparam logic [2:0] CAUSE_MRST  = 3'd1;
    localparam logic [2:0] CAUSE_KBD   = 3'd2;
    localparam logic [2:0] CAUSE_OSD   = 3'd3;
    localparam logic [2:0] CAUSE_RSTI  = 3'd4;
    localparam logic [2:0] CAUSE_BOOTD = 3'd5;

    typedef enum logic [1:0] {
        ST_FULL    = 2'd0,
        ST_CPUWAIT = 2'd1,
        ST_RUN     = 2'd2,
        ST_INSTR   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              boot_q, boot_d;
    logic [2:0]        cause_q, cause_d;

    logic              full_req;
    logic [2:0]        full_cause;
    logic [TICK_W-1:0] tick_inc;
    logic [CYC_W-1:0]  cyc_inc;

    // Request decode and saturating counter increments
    always_comb begin
        full_req = mrst | kbd_rst | osd_rst;
        if (mrst)
            full_cause = CAUSE_MRST;
        else if (kbd_rst)
            full_cause = CAUSE_KBD;
        else
            full_cause = CAUSE_OSD;
        tick_inc = (tick_q == TICK_LAST) ? tick_q : tick_q + TICK_W'(1);
        cyc_inc  = (cyc_q == CYC_SAT) ? cyc_q : cyc_q + CYC_W'(1);
    end

    // Next-state logic; everything advances only on clk7_en
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        cyc_d   = cyc_q;
        boot_d  = boot_q;
        cause_d = cause_q;
        if (clk7_en) begin
            case (state_q)
                ST_FULL: begin
                    if (full_req) begin
                        // retrigger: hold restarts from the last request
                        tick_d  = '0;
                        cause_d = full_cause;
                    end else if (cnt) begin
                        tick_d = tick_inc;
                        if (tick_inc == TICK_LAST) begin
                            cyc_d   = '0;
                            state_d = ST_CPUWAIT;
                        end
                    end
                end
                ST_CPUWAIT: begin
                    if (full_req) begin
                        tick_d  = '0;
                        cyc_d   = '0;
                        cause_d = full_cause;
                        state_d = ST_FULL;
                    end else if (cyc_q == CPU_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        cyc_d = cyc_inc;
                    end
                end
                ST_RUN: begin
                    if (full_req) begin
                        tick_d  = '0;
                        cause_d = full_cause;
                        state_d = ST_FULL;
                    end else if (bootdone && boot_q) begin
                        // boot ROM is unmapped and the machine restarts cleanly
                        boot_d  = 1'b0;
                        tick_d  = '0;
                        cause_d = CAUSE_BOOTD;
                        state_d = ST_FULL;
                    end else if (cpu_rsti) begin
                        cyc_d   = '0;
                        cause_d = CAUSE_RSTI;
                        state_d = ST_INSTR;
                    end
                end
                ST_INSTR: begin
                    // extra RESET instructions do not restart the window
                    if (full_req) begin
                        tick_d  = '0;
                        cyc_d   = '0;
                        cause_d = full_cause;
                        state_d = ST_FULL;
                    end else if (cyc_q == INSTR_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        cyc_d = cyc_inc;
                    end
                end
                default: begin
                    state_d = ST_FULL;
                    tick_d  = '0;
                end
            endcase
        end
    end

    // State registers; reset_n acts on any clk edge regardless of clk7_en
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_FULL;
            tick_q  <= '0;
            cyc_q   <= '0;
            boot_q  <= 1'b1;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            cyc_q   <= cyc_d;
            boot_q  <= boot_d;
            cause_q <= cause_d;
        end
    end

    // Output decode from the registered state
    always_comb begin
        periph_reset = 1'b0;
        cpu_reset    = 1'b0;
        busy         = 1'b0;
        case (state_q)
            ST_FULL: begin
                periph_reset = 1'b1;
                cpu_reset    = 1'b1;
                busy         = 1'b1;
            end
            ST_CPUWAIT: begin
                cpu_reset = 1'b1;
                busy      = 1'b1;
            end
            ST_INSTR: begin
                periph_reset = 1'b1;
                busy         = 1'b1;
            end
            default: begin
                periph_reset = 1'b0;
                cpu_reset    = 1'b0;
                busy         = 1'b0;
            end
        endcase
        boot  = boot_q;
        cause = cause_q;
    end

endmodule

// File: tb/tb_minimig_reset_sequencer.sv
// Directed bench for minimig_reset_sequencer: a vector table for power-on and
// keyboard sequencing, then hand-written multi-cycle corner-case sequences.
module tb_minimig_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n, clk7_en, cnt, mrst, kbd_rst, osd_rst, cpu_rsti, bootdone;
    logic       periph_reset, cpu_reset, boot, busy;
    logic [2:0] cause;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    minimig_reset_sequencer #(
        .HOLD_TICKS(4),
        .CPU_DELAY(8),
        .INSTR_CYCLES(124)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clk7_en(clk7_en),
        .cnt(cnt),
        .mrst(mrst),
        .kbd_rst(kbd_rst),
        .osd_rst(osd_rst),
        .cpu_rsti(cpu_rsti),
        .bootdone(bootdone),
        .periph_reset(periph_reset),
        .cpu_reset(cpu_reset),
        .boot(boot),
        .busy(busy),
        .cause(cause)
    );

    // input bits: reset_n, clk7_en, cnt, mrst, kbd_rst, osd_rst, cpu_rsti, bootdone
    typedef struct packed {
        logic rst_n, en, cnt, mrst, kbd, osd, rsti, bd;
    } in_t;
    typedef struct packed {
        logic       periph, cpu, boot, busy;
        logic [2:0] cause;
    } out_t;
    typedef struct {
        in_t  in;
        int   reps;
        out_t exp;
    } vec_t;

    localparam in_t I_RST      = 8'b0100_0000;
    localparam in_t I_RST_NOEN = 8'b0000_0000;
    localparam in_t I_EN       = 8'b1100_0000;
    localparam in_t I_CNT      = 8'b1110_0000;
    localparam in_t I_CNT_NOEN = 8'b1010_0000;
    localparam in_t I_MRST     = 8'b1101_0000;
    localparam in_t I_MRST_CNT = 8'b1111_0000;
    localparam in_t I_KBD_OSD  = 8'b1100_1100;
    localparam in_t I_OSD      = 8'b1100_0100;
    localparam in_t I_RSTI     = 8'b1100_0010;
    localparam in_t I_RSTI_NOEN= 8'b1000_0010;
    localparam in_t I_BD       = 8'b1100_0001;
    localparam in_t I_BD_NOEN  = 8'b1000_0001;
    localparam in_t I_MRST_BD  = 8'b1101_0001;

    localparam int S_FULL = 0;
    localparam int S_CW   = 1;
    localparam int S_RUN  = 2;
    localparam int S_IN   = 3;

    // expected outputs for a state, boot flag and cause
    function automatic out_t ex(input int st, input logic b, input logic [2:0] c);
        out_t o;
        o.boot  = b;
        o.cause = c;
        case (st)
            S_FULL:  begin o.periph = 1'b1; o.cpu = 1'b1; o.busy = 1'b1; end
            S_CW:    begin o.periph = 1'b0; o.cpu = 1'b1; o.busy = 1'b1; end
            S_IN:    begin o.periph = 1'b1; o.cpu = 1'b0; o.busy = 1'b1; end
            default: begin o.periph = 1'b0; o.cpu = 1'b0; o.busy = 1'b0; end
        endcase
        return o;
    endfunction

    // drive one input vector for reps clocks, checking outputs after each edge
    task automatic apply(input string tag, input in_t in, input int reps, input out_t exp);
        out_t act;
        int bad = 0;
        for (int r = 0; r < reps; r++) begin
            {reset_n, clk7_en, cnt, mrst, kbd_rst, osd_rst, cpu_rsti, bootdone} = in;
            @(posedge clk);
            #1;
            act = {periph_reset, cpu_reset, boot, busy, cause};
            n_vec++;
            if (act !== exp) begin
                n_miss++;
                bad++;
                $display("FAIL %s rep %0d: got periph=%b cpu=%b boot=%b busy=%b cause=%0d, want periph=%b cpu=%b boot=%b busy=%b cause=%0d",
                         tag, r, act.periph, act.cpu, act.boot, act.busy, act.cause,
                         exp.periph, exp.cpu, exp.boot, exp.busy, exp.cause);
            end
        end
        $display("%s: in=%b x%0d, %0d bad", tag, in, reps, bad);
    endtask

    // four cnt ticks release peripherals, then eight CPUWAIT cycles to RUN
    task automatic release_seq(input string tag, input logic b, input logic [2:0] c);
        apply({tag, " cnt1-3"}, I_CNT, 3, ex(S_FULL, b, c));
        apply({tag, " cnt4"},   I_CNT, 1, ex(S_CW, b, c));
        apply({tag, " cpuwait"},I_EN,  7, ex(S_CW, b, c));
        apply({tag, " run"},    I_EN,  1, ex(S_RUN, b, c));
    endtask

    vec_t tbl[$];

    initial begin
        {reset_n, clk7_en, cnt, mrst, kbd_rst, osd_rst, cpu_rsti, bootdone} = I_RST;

        // power-on with a cnt every 16 clk7_en, then a keyboard+OSD reset
        tbl.push_back('{I_RST,      3,  ex(S_FULL, 1'b1, 3'd0)});
        tbl.push_back('{I_EN,       15, ex(S_FULL, 1'b1, 3'd0)});
        tbl.push_back('{I_CNT_NOEN, 2,  ex(S_FULL, 1'b1, 3'd0)});
        tbl.push_back('{I_CNT,      1,  ex(S_FULL, 1'b1, 3'd0)});
        tbl.push_back('{I_EN,       15, ex(S_FULL, 1'b1, 3'd0)});
        tbl.push_back('{I_CNT,      1,  ex(S_FULL, 1'b1, 3'd0)});
        tbl.push_back('{I_EN,       15, ex(S_FULL, 1'b1, 3'd0)});
        tbl.push_back('{I_CNT,      1,  ex(S_FULL, 1'b1, 3'd0)});
        tbl.push_back('{I_EN,       15, ex(S_FULL, 1'b1, 3'd0)});
        tbl.push_back('{I_CNT,      1,  ex(S_CW,   1'b1, 3'd0)});
        tbl.push_back('{I_EN,       7,  ex(S_CW,   1'b1, 3'd0)});
        tbl.push_back('{I_EN,       1,  ex(S_RUN,  1'b1, 3'd0)});
        tbl.push_back('{I_RSTI_NOEN,1,  ex(S_RUN,  1'b1, 3'd0)});
        tbl.push_back('{I_BD_NOEN,  1,  ex(S_RUN,  1'b1, 3'd0)});
        tbl.push_back('{I_EN,       3,  ex(S_RUN,  1'b1, 3'd0)});
        tbl.push_back('{I_KBD_OSD,  1,  ex(S_FULL, 1'b1, 3'd2)});
        tbl.push_back('{I_CNT,      3,  ex(S_FULL, 1'b1, 3'd2)});
        tbl.push_back('{I_CNT,      1,  ex(S_CW,   1'b1, 3'd2)});
        tbl.push_back('{I_EN,       7,  ex(S_CW,   1'b1, 3'd2)});
        tbl.push_back('{I_EN,       1,  ex(S_RUN,  1'b1, 3'd2)});

        for (int k = 0; k < tbl.size(); k++)
            apply($sformatf("tbl[%0d]", k), tbl[k].in, tbl[k].reps, tbl[k].exp);

        // RESET instruction: 124-cycle peripheral reset, second pulse ignored
        apply("rsti entry",  I_RSTI, 1,  ex(S_IN, 1'b1, 3'd4));
        apply("rsti 1-49",   I_EN,   49, ex(S_IN, 1'b1, 3'd4));
        apply("rsti again",  I_RSTI, 1,  ex(S_IN, 1'b1, 3'd4));
        apply("rsti 51-123", I_EN,   73, ex(S_IN, 1'b1, 3'd4));
        apply("rsti exit",   I_EN,   1,  ex(S_RUN, 1'b1, 3'd4));

        // bootdone with boot=1 clears boot and runs a full sequence
        apply("bootdone", I_BD, 1, ex(S_FULL, 1'b0, 3'd5));
        release_seq("bootdone", 1'b0, 3'd5);
        apply("bootdone 2nd", I_BD, 1, ex(S_RUN, 1'b0, 3'd5));
        apply("idle",         I_EN, 3, ex(S_RUN, 1'b0, 3'd5));

        // mrst held 100 clk7_en, cnt during hold does not count
        apply("mrst hold a", I_MRST,     50, ex(S_FULL, 1'b0, 3'd1));
        apply("mrst cnt",    I_MRST_CNT, 1,  ex(S_FULL, 1'b0, 3'd1));
        apply("mrst hold b", I_MRST,     49, ex(S_FULL, 1'b0, 3'd1));
        release_seq("mrst", 1'b0, 3'd1);

        // OSD reset aborts an INSTR window at cycle 60
        apply("instr entry", I_RSTI, 1,  ex(S_IN, 1'b0, 3'd4));
        apply("instr 1-59",  I_EN,   59, ex(S_IN, 1'b0, 3'd4));
        apply("osd abort",   I_OSD,  1,  ex(S_FULL, 1'b0, 3'd3));
        release_seq("osd", 1'b0, 3'd3);

        // reset_n restores boot; mrst beats a simultaneous bootdone
        apply("por again", I_RST, 2, ex(S_FULL, 1'b1, 3'd0));
        release_seq("por", 1'b1, 3'd0);
        apply("mrst+bd",   I_MRST_BD, 1, ex(S_FULL, 1'b1, 3'd1));
        apply("mrst+bd cnt1-3", I_CNT, 3, ex(S_FULL, 1'b1, 3'd1));
        apply("mrst+bd cnt4",   I_CNT, 1, ex(S_CW, 1'b1, 3'd1));
        apply("cpuwait",        I_EN,  3, ex(S_CW, 1'b1, 3'd1));

        // reset_n in CPUWAIT without clk7_en still forces FULL
        apply("rst in cw", I_RST_NOEN, 1, ex(S_FULL, 1'b1, 3'd0));
        apply("cnt noen",  I_CNT_NOEN, 3, ex(S_FULL, 1'b1, 3'd0));
        release_seq("final", 1'b1, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
